// File: rtl/medium_array_feeder.sv
// medium_array_feeder
//   Byte FIFO that sits in front of the array-processor/accumulator stage.
//   Upstream: valid/ready. Downstream: the consumer pulls one byte per cycle
//   with out_en, because the accumulator cannot apply back-pressure.
//   Every FRAME_LEN-th emitted byte is tagged with frame_last, which keeps the
//   consumer's frame index aligned.
//
//   Optional build macro: MEDIUM_FEEDER_CKSUM_EN
//     When it is defined, a per-frame checksum (sum mod 2^DW of the frame's
//     bytes) is emitted on cksum_out. It comes with a one-cycle cksum_valid
//     pulse that is aligned with frame_last.
//
// Handshake semantics:
//   Upstream:   a byte transfers on a rising edge where in_valid && in_ready.
//               in_valid may be high while in_ready is low. The source must
//               then hold in_data steady until the transfer happens.
//   Downstream: out_en is a request, not a handshake. On an edge where out_en
//               is high and the FIFO is not empty, one byte is popped. It is
//               presented on out_data with out_valid=1 for the following cycle.

module medium_array_feeder #(
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int FRAME_LEN = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          flush,
  input  logic          out_en,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          frame_last,
  output logic [AW:0]   level
`ifdef MEDIUM_FEEDER_CKSUM_EN
  ,
  output logic [DW-1:0] cksum_out,
  output logic          cksum_valid
`endif
);

  localparam int LW  = AW + 1;
  localparam int FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [LW-1:0]  FULL_LEVEL     = LW'(DEPTH);
  localparam logic [FCW-1:0] FRAME_LAST_CNT = FCW'(FRAME_LEN - 1);

  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [FCW-1:0] frame_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic frame_end;

  // Flush blocks both sides of the FIFO in the cycle it is asserted.
  // This lets flush take priority without any extra qualification further down.
  always_comb begin
    full      = (level == FULL_LEVEL);
    empty     = (level == '0);
    in_ready  = !full && !flush;
    push      = in_valid && in_ready;
    pop       = out_en && !empty && !flush;
    frame_end = (frame_cnt == FRAME_LAST_CNT);
  end

  // Storage write. The array is left unreset on purpose: level decides what
  // is valid, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, occupancy, frame position and the registered output byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      frame_cnt  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_last <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      frame_cnt  <= '0;
      out_valid  <= 1'b0;
      frame_last <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      out_valid  <= pop;
      frame_last <= pop && frame_end;
      if (pop) begin
        out_data  <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
        frame_cnt <= frame_end ? '0 : frame_cnt + FCW'(1);
      end
    end
  end

`ifdef MEDIUM_FEEDER_CKSUM_EN
  logic [DW-1:0] acc;
  logic [DW-1:0] acc_next;

  // Running frame sum including the byte being popped this cycle.
  always_comb begin
    acc_next = acc + mem[rd_ptr];
  end

  // Per-frame checksum. It is published together with the frame's last byte,
  // and the accumulator restarts from zero for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      cksum_out   <= '0;
      cksum_valid <= 1'b0;
    end else if (flush) begin
      acc         <= '0;
      cksum_valid <= 1'b0;
    end else if (pop) begin
      if (frame_end) begin
        acc         <= '0;
        cksum_out   <= acc_next;
        cksum_valid <= 1'b1;
      end else begin
        acc         <= acc_next;
        cksum_valid <= 1'b0;
      end
    end else begin
      cksum_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_medium_array_feeder.sv
// tb_medium_array_feeder
//   Randomised and directed stimulus for medium_array_feeder.
//   A queue-based reference model predicts every emitted byte, plus its
//   frame tag and checksum, and pushes each prediction into exp_q. A monitor
//   that runs once per cycle pops from exp_q and compares.
//   Build with +define+MEDIUM_FEEDER_CKSUM_EN to also cover the checksum.

module tb_medium_array_feeder;

  localparam int DW        = 8;
  localparam int DEPTH     = 8;
  localparam int AW        = 3;
  localparam int FRAME_LEN = 8;
  localparam int EW        = 2 * DW + 1;   // {cksum, last, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_en;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          frame_last;
  logic [AW:0]   level;
`ifdef MEDIUM_FEEDER_CKSUM_EN
  logic [DW-1:0] cksum_out;
  logic          cksum_valid;
`endif

  medium_array_feeder #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_en     (out_en),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_last (frame_last),
    .level      (level)
`ifdef MEDIUM_FEEDER_CKSUM_EN
    ,
    .cksum_out  (cksum_out),
    .cksum_valid(cksum_valid)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_total = 0;
  int n_pass  = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] m_q[$];          // model FIFO contents
  logic [DW-1:0] frame_bytes[$];  // bytes emitted so far in the current frame
  int            emit_idx;        // bytes emitted since reset/flush
  bit            accepted;        // model: in_data was taken at the last edge
  logic [DW-1:0] last_data;       // last byte the DUT should be holding
  logic [DW-1:0] ck_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Upstream acceptance is predicted from the model's occupancy. The frame
  // tag is derived from the running emission index. The checksum is the plain
  // sum of the bytes in the frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      frame_bytes.delete();
      exp_q.delete();
      emit_idx = 0;
      accepted = 1'b0;
    end else begin
      bit do_push, do_pop, last;
      logic [DW-1:0] b, ck;
      do_push = in_valid && (m_q.size() < DEPTH) && !flush;
      do_pop  = out_en && (m_q.size() != 0) && !flush;
      if (flush) begin
        m_q.delete();
        frame_bytes.delete();
        emit_idx = 0;
      end else begin
        if (do_pop) begin
          b = m_q.pop_front();
          frame_bytes.push_back(b);
          last = ((emit_idx % FRAME_LEN) == FRAME_LEN - 1);
          ck = '0;
          if (last) begin
            int s;
            s = 0;
            foreach (frame_bytes[i]) s += int'(frame_bytes[i]);
            ck = DW'(s % 256);
            frame_bytes.delete();
          end
          emit_idx++;
          exp_q.push_back({ck, last, b});
        end
        if (do_push) m_q.push_back(in_data);
      end
      accepted = do_push;
    end
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    chk("level", 32'(level), 32'(m_q.size()));
    chk("in_ready", 32'(in_ready), 32'((m_q.size() < DEPTH) && !flush));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'(1'b0));
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
        chk("frame_last", 32'(frame_last), 32'(e[DW]));
        last_data = e[DW-1:0];
`ifdef MEDIUM_FEEDER_CKSUM_EN
        chk("cksum_valid", 32'(cksum_valid), 32'(e[DW]));
        if (e[DW]) begin
          chk("cksum_out", 32'(cksum_out), 32'(e[EW-1:DW+1]));
          ck_seen = cksum_out;
        end
`endif
      end
    end else begin
      if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        chk("missing_valid", 32'(out_valid), 32'(1'b1));
      end
      chk("frame_last_idle", 32'(frame_last), 32'(1'b0));
      chk("out_data_hold", 32'(out_data), 32'(last_data));
`ifdef MEDIUM_FEEDER_CKSUM_EN
      chk("cksum_valid_idle", 32'(cksum_valid), 32'(1'b0));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  // Apply inputs at a falling edge and hold them until the next falling edge.
  task automatic tick(input logic iv, input logic [DW-1:0] d, input logic oe, input logic fl);
    in_valid = iv;
    in_data  = d;
    out_en   = oe;
    flush    = fl;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Random phase. in_data is held while it has not yet been accepted.
  task automatic random_phase(input int cycles, input int oe_pct, input int iv_pct);
    for (int c = 0; c < cycles; c++) begin
      if (!in_valid || accepted) begin
        in_valid = ($urandom_range(0, 99) < iv_pct);
        in_data  = DW'($urandom_range(0, 255));
      end
      out_en = ($urandom_range(0, 99) < oe_pct);
      flush  = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; out_en = 1'b0; flush = 1'b0;
    last_data = '0;
    ck_seen = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: asynchronous reset mid-stream, level=5, with non-zero out_data
    for (int i = 0; i < 6; i++) tick(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0);
    in_valid = 1'b0; out_en = 1'b0;
    chk("pre_reset_level", 32'(level), 32'd5);
    #2 rst_n = 1'b0;
    last_data = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_last", 32'(frame_last), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef MEDIUM_FEEDER_CKSUM_EN
    chk("rst_cksum_out", 32'(cksum_out), 32'd0);
    chk("rst_cksum_valid", 32'(cksum_valid), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 2: fill to full, then hold a 9th byte that must wait for the first pop
    for (int i = 1; i <= 8; i++) tick(1'b1, DW'(i), 1'b0, 1'b0);
    chk("fill_level", 32'(level), 32'd8);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h09, 1'b0, 1'b0);
    chk("held_level", 32'(level), 32'd8);

    // 3: drain in order. The 9th byte enters right after the first pop.
    tick(1'b1, 8'h09, 1'b1, 1'b0);
    tick(1'b1, 8'h09, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b0, '0, 1'b1, 1'b0);
    chk("drain_level", 32'(level), 32'd0);
    idle(2);

    // 4: concurrent push and pop at level 4 for 20 cycles
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, DW'(8'h50 + i), 1'b1, 1'b0);
    chk("concurrent_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1, 1'b0);
    idle(2);

    // 5: flush at level 6 with frame_cnt 3, and with push and pop requested
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, DW'(8'h64 + i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b1, DW'(8'h67 + i), 1'b0, 1'b0);
    chk("preflush_level", 32'(level), 32'd6);
    tick(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("flush_level", 32'(level), 32'd0);
    for (int i = 0; i < 8; i++) tick(1'b1, DW'(8'h70 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
    idle(2);

`ifdef MEDIUM_FEEDER_CKSUM_EN
    // 6: known checksum frame, then a fresh frame starting from acc=0
    begin
      logic [DW-1:0] pat [8];
      pat = '{8'h80, 8'h90, 8'h10, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04};
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) tick(1'b1, pat[i], 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) tick(1'b0, '0, 1'b1, 1'b0);
      chk("cksum_known", 32'(ck_seen), 32'h4A);
      for (int i = 0; i < 8; i++) tick(1'b1, 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) tick(1'b0, '0, 1'b1, 1'b0);
      chk("cksum_restart", 32'(ck_seen), 32'h08);
    end
`endif

    // out_en on an empty FIFO must not disturb the frame position
    tick(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, DW'(8'h90 + i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);

    // random traffic: fill-biased, balanced, then drain-biased
    in_valid = 1'b0;
    random_phase(600, 25, 80);
    random_phase(800, 60, 60);
    random_phase(600, 85, 30);

    // final drain
    for (int i = 0; i < DEPTH + 2; i++) tick(1'b0, '0, 1'b1, 1'b0);
    idle(2);
    chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
